// File: rtl/ps2_scancode_rx_if.sv
// PS/2 line inputs and decoded scancode outputs of the frame receiver.
// The receiver side drives the scancode strobes; the host side drives the raw lines.
interface ps2_scancode_rx_if;
   logic       ps2_clk;
   logic       ps2_data;
   logic [7:0] scancode;
   logic       scancode_valid;
   logic       extended;
   logic       frame_err;

   modport master (
      input  ps2_clk,
      input  ps2_data,
      output scancode,
      output scancode_valid,
      output extended,
      output frame_err
   );

   modport slave (
      output ps2_clk,
      output ps2_data,
      input  scancode,
      input  scancode_valid,
      input  extended,
      input  frame_err
   );
endinterface

// File: rtl/ps2_scancode_rx.sv
// PS/2 frame receiver: make codes out as a strobe 1 clk after the stop-bit fall is detected.
// No backpressure: scancode_valid/frame_err are single-cycle pulses the consumer must take.
module ps2_scancode_rx #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input logic             clk,
   input logic             rstn,
   ps2_scancode_rx_if.master bus
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          clk_filt, fall, fall_dat;
   logic [FW-1:0] filt_cnt;

   state_t        state, state_nxt;
   logic [2:0]    bitcnt, bitcnt_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic          par_bit, par_bit_nxt;
   logic          ext_flag, ext_flag_nxt;
   logic          brk_flag, brk_flag_nxt;
   logic [TW-1:0] tmo_cnt, tmo_cnt_nxt;
   logic [7:0]    scancode_q, scancode_nxt;
   logic          valid_q, valid_nxt;
   logic          ext_q, ext_nxt;
   logic          err_q, err_nxt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= bus.ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= bus.ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         clk_filt <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
         fall_dat <= 1'b1;
      end else begin
         fall     <= 1'b0;
         fall_dat <= dat_s2;
         if (clk_s2 == clk_filt) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            clk_filt <= clk_s2;
            filt_cnt <= '0;
            fall     <= clk_filt;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= IDLE;
         bitcnt     <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         ext_flag   <= 1'b0;
         brk_flag   <= 1'b0;
         tmo_cnt    <= '0;
         scancode_q <= 8'h00;
         valid_q    <= 1'b0;
         ext_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_nxt;
         bitcnt     <= bitcnt_nxt;
         shreg      <= shreg_nxt;
         par_bit    <= par_bit_nxt;
         ext_flag   <= ext_flag_nxt;
         brk_flag   <= brk_flag_nxt;
         tmo_cnt    <= tmo_cnt_nxt;
         scancode_q <= scancode_nxt;
         valid_q    <= valid_nxt;
         ext_q      <= ext_nxt;
         err_q      <= err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bitcnt_nxt   = bitcnt;
      shreg_nxt    = shreg;
      par_bit_nxt  = par_bit;
      ext_flag_nxt = ext_flag;
      brk_flag_nxt = brk_flag;
      scancode_nxt = scancode_q;
      ext_nxt      = ext_q;
      valid_nxt    = 1'b0;
      err_nxt      = 1'b0;

      if (state == IDLE || fall)
         tmo_cnt_nxt = '0;
      else
         tmo_cnt_nxt = tmo_cnt + 1'b1;

      case (state)
         IDLE: begin
            if (fall) begin
               if (!fall_dat) begin
                  state_nxt  = DATA;
                  bitcnt_nxt = '0;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         DATA: begin
            if (fall) begin
               shreg_nxt  = {fall_dat, shreg[7:1]};
               bitcnt_nxt = bitcnt + 1'b1;
               if (bitcnt == 3'd7)
                  state_nxt = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_bit_nxt = fall_dat;
               state_nxt   = STOP;
            end
         end
         STOP: begin
            if (fall) begin
               state_nxt = IDLE;
               if ((^{shreg, par_bit}) && fall_dat) begin
                  // Prefixes only arm flags; a break-prefixed byte is swallowed.
                  if (shreg == 8'hE0) begin
                     ext_flag_nxt = 1'b1;
                  end else if (shreg == 8'hF0) begin
                     brk_flag_nxt = 1'b1;
                  end else begin
                     if (!brk_flag) begin
                        scancode_nxt = shreg;
                        ext_nxt      = ext_flag;
                        valid_nxt    = 1'b1;
                     end
                     ext_flag_nxt = 1'b0;
                     brk_flag_nxt = 1'b0;
                  end
               end else begin
                  err_nxt      = 1'b1;
                  ext_flag_nxt = 1'b0;
                  brk_flag_nxt = 1'b0;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (state != IDLE && !fall && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
         state_nxt    = IDLE;
         tmo_cnt_nxt  = '0;
         err_nxt      = 1'b1;
         ext_flag_nxt = 1'b0;
         brk_flag_nxt = 1'b0;
      end
   end

   assign bus.scancode       = scancode_q;
   assign bus.scancode_valid = valid_q;
   assign bus.extended       = ext_q;
   assign bus.frame_err      = err_q;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed PS/2 frames with an expected-output queue checked by an independent monitor.
module tb_ps2_scancode_rx;
   localparam int FL   = 8;
   localparam int TMO  = 1000;
   localparam int HALF = 20;

   typedef struct packed {
      logic       err;
      logic       ext;
      logic [7:0] code;
   } exp_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   stop_cyc = 0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ps2_scancode_rx_if bus ();

   ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Drives nb bits of a frame (start, data LSB first, parity, stop); data changes while clock high.
   task automatic send(input logic [7:0] b, input bit bad_par, input int nb, input bit glitch);
      logic [10:0] f;
      logic        p;
      p = ~^b;
      if (bad_par) p = ~p;
      f = {1'b1, p, b, 1'b0};
      for (int i = 0; i < nb; i++) begin
         @(posedge clk); #1 bus.ps2_data = f[i];
         repeat (HALF / 2) @(posedge clk);
         if (glitch) begin
            #1 bus.ps2_clk = 1'b0;
            @(posedge clk); #1 bus.ps2_clk = 1'b1;
         end
         repeat (HALF / 2) @(posedge clk);
         #1 bus.ps2_clk = 1'b0;
         if (i == 10) stop_cyc = cyc;
         repeat (HALF) @(posedge clk);
         #1 bus.ps2_clk = 1'b1;
      end
      repeat (HALF) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (rstn && (bus.scancode_valid || bus.frame_err)) begin
         check("valid_err_exclusive", {31'd0, bus.scancode_valid & bus.frame_err}, 32'd0);
         if (exp_q.size() == 0) begin
            check("unexpected_output", {30'd0, bus.scancode_valid, bus.frame_err}, 32'd0);
         end else begin
            exp_t e;
            int   lat;
            e = exp_q.pop_front();
            check("frame_err", {31'd0, bus.frame_err}, {31'd0, e.err});
            if (!e.err) begin
               check("scancode", {24'd0, bus.scancode}, {24'd0, e.code});
               check("extended", {31'd0, bus.extended}, {31'd0, e.ext});
               lat = cyc - stop_cyc;
               total++;
               if (lat < FL + 1 || lat > FL + 6) begin
                  bad++;
                  $display("FAIL latency actual=%0d required=%0d..%0d", lat, FL + 1, FL + 6);
               end
            end
         end
      end
   end

   initial begin
      bus.ps2_clk  = 1'b1;
      bus.ps2_data = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_scancode", {24'd0, bus.scancode}, 32'h00);
      check("rst_valid", {31'd0, bus.scancode_valid}, 32'd0);
      check("rst_extended", {31'd0, bus.extended}, 32'd0);
      check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      rstn = 1'b1;
      repeat (10) @(posedge clk);

      // T1
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h75});
      send(8'h75, 1'b0, 11, 1'b0);

      // T2: extended make, break sequence, plain make
      exp_q.push_back('{err: 1'b0, ext: 1'b1, code: 8'h6B});
      send(8'hE0, 1'b0, 11, 1'b0);
      send(8'h6B, 1'b0, 11, 1'b0);
      send(8'hF0, 1'b0, 11, 1'b0);
      send(8'h6B, 1'b0, 11, 1'b0);
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h74});
      send(8'h74, 1'b0, 11, 1'b0);

      // T3: parity error then recovery
      exp_q.push_back('{err: 1'b1, ext: 1'b0, code: 8'h00});
      send(8'h74, 1'b1, 11, 1'b0);
      check("held_after_err", {24'd0, bus.scancode}, 32'h74);
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h73});
      send(8'h73, 1'b0, 11, 1'b0);

      // T4: clock stalls after four data bits
      exp_q.push_back('{err: 1'b1, ext: 1'b0, code: 8'h00});
      send(8'h6B, 1'b0, 5, 1'b0);
      repeat (TMO + 200) @(posedge clk);
      check("queue_after_timeout", exp_q.size(), 32'd0);
      check("held_after_timeout", {24'd0, bus.scancode}, 32'h73);
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h6B});
      send(8'h6B, 1'b0, 11, 1'b0);

      // T5: short low glitches on ps2_clk
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h75});
      send(8'h75, 1'b0, 11, 1'b1);

      // T6: reset mid-frame (after data bit 3)
      send(8'h75, 1'b0, 5, 1'b0);
      #1 rstn = 1'b0;
      bus.ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_scancode", {24'd0, bus.scancode}, 32'h00);
      check("midrst_valid", {31'd0, bus.scancode_valid}, 32'd0);
      check("midrst_extended", {31'd0, bus.extended}, 32'd0);
      check("midrst_frame_err", {31'd0, bus.frame_err}, 32'd0);
      rstn = 1'b1;
      repeat (10) @(posedge clk);
      exp_q.push_back('{err: 1'b0, ext: 1'b0, code: 8'h75});
      send(8'h75, 1'b0, 11, 1'b0);

      repeat (100) @(posedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
